// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared channel count, FSM state type and enabled-channel search helpers.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    typedef enum logic {IDLE, SCAN} state_e;
    typedef struct packed {
        logic [1:0] ch;
        logic       last;
    } pick_t;
    // last=1 when no enabled channel lies above cur; cur=-1 searches from channel 0
    function automatic pick_t next_en(input logic [NUM_CH-1:0] mask, input int cur);
        pick_t p;
        p = '{ch: 2'd0, last: 1'b1};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && i > cur) begin
                p.ch   = 2'(i);
                p.last = 1'b0;
            end
        end
        return p;
    endfunction
    function automatic logic [1:0] first_en(input logic [NUM_CH-1:0] mask);
        pick_t p;
        p = next_en(mask, -1);
        return p.ch;
    endfunction
endpackage

// File: rtl/mux_scan_sequencer_chan_pick.sv
// chan_pick: combinational finder of the next enabled channel above cur_i (cur_i=-1 gives the first).
module chan_pick
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic signed [2:0] cur_i,
    output logic [1:0]        ch_o,
    output logic              last_o
);
    pick_t p;
    assign p      = next_en(mask_i, int'(cur_i));
    assign ch_o   = p.ch;
    assign last_o = p.last;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps sel over enabled mux channels, samples mux_f per dwell,
// and publishes one 4-bit frame per pass with a single-cycle valid strobe.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              mux_f_i,
    output logic [1:0]        sel_o,
    output logic [NUM_CH-1:0] frame_o,
    output logic              frame_valid_o,
    output logic              busy_o
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0] snap_q, snap_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [1:0]        sel_q, sel_d;
    logic              fv_q, fv_d;
    logic [1:0]        next_ch, first_ch;
    logic              is_last, mask_empty;
    logic              done, start;
    logic [NUM_CH-1:0] merged;

    chan_pick u_next (
        .mask_i (snap_q),
        .cur_i  ($signed({1'b0, sel_q})),
        .ch_o   (next_ch),
        .last_o (is_last)
    );

    chan_pick u_first (
        .mask_i (mask_i),
        .cur_i  (3'sb111),
        .ch_o   (first_ch),
        .last_o (mask_empty)
    );

    assign done   = cnt_q == CW'(DWELL - 1);
    assign start  = en_i && !mask_empty;
    assign merged = shadow_q | (NUM_CH'(mux_f_i) << sel_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        sel_d    = sel_q;
        fv_d     = 1'b0;
        if (state_q == IDLE) begin
            shadow_d = '0;
            sel_d    = 2'd0;
            if (start) begin
                snap_d  = mask_i;
                sel_d   = first_ch;
                cnt_d   = '0;
                state_d = SCAN;
            end
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d    = '0;
            shadow_d = merged;
            sel_d    = next_ch;
            if (is_last) begin
                frame_d  = merged;
                fv_d     = 1'b1;
                shadow_d = '0;
                snap_d   = start ? mask_i : snap_q;
                sel_d    = start ? first_ch : 2'd0;
                state_d  = start ? SCAN : IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            sel_q    <= 2'd0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            sel_q    <= sel_d;
            fv_q     <= fv_d;
        end
    end

    assign sel_o         = sel_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = fv_q;
    assign busy_o        = state_q == SCAN;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed scenarios with hand-computed sel/frame/strobe expectations.
module tb_mux_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst, en, mux_f, fv, busy;
    logic [3:0] mask, frame, pat;
    logic [1:0] sel;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    assign mux_f = pat[sel];

    mux_scan_sequencer #(.DWELL(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .mask_i        (mask),
        .mux_f_i       (mux_f),
        .sel_o         (sel),
        .frame_o       (frame),
        .frame_valid_o (fv),
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mask = 4'b0000; pat = 4'b0000;
        tick(); tick();
        n_checks++;
        if ({sel, frame, fv, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_init: sel=%0d frame=%b fv=%b busy=%b, want all 0", sel, frame, fv, busy);
        end
        rst = 1'b0; en = 1'b1; mask = 4'b1111; pat = 4'b1111;
        tick();
        en = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, sel} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_pre: busy=%b sel=%0d, want busy=1 sel=0", busy, sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({sel, frame, fv, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: sel=%0d frame=%b fv=%b busy=%b, want all 0", sel, frame, fv, busy);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({fv, busy, frame} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_after[%0d]: fv=%b busy=%b frame=%b, want 0", k, fv, busy, frame);
            end
        end
    endtask

    task automatic test_full_scan();
        pat = 4'b1101; mask = 4'b1111; en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({sel, busy, fv} !== {2'(k / 4), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL full_seq[%0d]: sel=%0d busy=%b fv=%b, want sel=%0d busy=1 fv=0", k, sel, busy, fv, k / 4);
            end
            tick();
        end
        n_checks++;
        if ({fv, frame, busy, sel} !== {1'b1, 4'b1101, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL full_frame: fv=%b frame=%b busy=%b sel=%0d, want fv=1 frame=1101 busy=0 sel=0", fv, frame, busy, sel);
        end
        tick();
        n_checks++;
        if ({fv, busy, frame} !== {1'b0, 1'b0, 4'b1101}) begin
            n_fail++;
            $display("FAIL full_after: fv=%b busy=%b frame=%b, want fv=0 busy=0 frame=1101", fv, busy, frame);
        end
    endtask

    task automatic test_sparse();
        pat = 4'b1111; mask = 4'b1010; en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({sel, busy, fv} !== {(k < 4) ? 2'd1 : 2'd3, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL sparse_seq[%0d]: sel=%0d busy=%b fv=%b, want sel=%0d", k, sel, busy, fv, (k < 4) ? 1 : 3);
            end
            tick();
        end
        n_checks++;
        if ({fv, frame, busy} !== {1'b1, 4'b1010, 1'b0}) begin
            n_fail++;
            $display("FAIL sparse_frame: fv=%b frame=%b busy=%b, want fv=1 frame=1010 busy=0", fv, frame, busy);
        end
    endtask

    task automatic test_back_to_back();
        pat = 4'b0001; mask = 4'b0011; en = 1'b1;
        tick();
        for (int k = 1; k <= 24; k++) begin
            tick();
            n_checks++;
            if ({busy, fv, sel} !== {1'b1, k % 8 == 0, ((k % 8) < 4) ? 2'd0 : 2'd1}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: busy=%b fv=%b sel=%0d, want busy=1 fv=%0d sel=%0d", k, busy, fv, sel, k % 8 == 0, ((k % 8) < 4) ? 0 : 1);
            end
            if (k % 8 == 0) begin
                n_checks++;
                if (frame !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL b2b_frame[%0d]: frame=%b, want 0001", k, frame);
                end
            end
        end
        en = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if ({fv, busy, sel} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL b2b_stop: fv=%b busy=%b sel=%0d, want fv=1 busy=0 sel=0", fv, busy, sel);
        end
    endtask

    task automatic test_mid_frame();
        pat = 4'b0111; mask = 4'b1111; en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        mask = 4'b0001; en = 1'b0;
        for (int k = 4; k < 16; k++) begin
            n_checks++;
            if ({sel, busy, fv} !== {2'(k / 4), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_seq[%0d]: sel=%0d busy=%b fv=%b, want sel=%0d busy=1 fv=0", k, sel, busy, fv, k / 4);
            end
            tick();
        end
        n_checks++;
        if ({fv, frame, busy} !== {1'b1, 4'b0111, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_frame: fv=%b frame=%b busy=%b, want fv=1 frame=0111 busy=0", fv, frame, busy);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({sel, busy, fv} !== {2'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_restart[%0d]: sel=%0d busy=%b fv=%b, want sel=0 busy=1 fv=0", k, sel, busy, fv);
            end
            tick();
        end
        n_checks++;
        if ({fv, frame, busy} !== {1'b1, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_restart_frame: fv=%b frame=%b busy=%b, want fv=1 frame=0001 busy=0", fv, frame, busy);
        end
    endtask

    task automatic test_zero_mask();
        pat = 4'b1111; mask = 4'b0000; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if ({busy, sel, fv} !== 4'b0000) begin
                n_fail++;
                $display("FAIL zero_mask[%0d]: busy=%b sel=%0d fv=%b, want all 0", k, busy, sel, fv);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_back_to_back();
        test_mid_frame();
        test_zero_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
